// File: rtl/regfile_write_sequencer.sv
// Merges single-cycle ALU results and buffered late load returns onto the register
// file's single write port, and tracks registers with loads still in flight.
module regfile_write_sequencer #(
  parameter int DW    = 16,
  parameter int AW    = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_wr_en,
  input  logic [AW-1:0]            alu_wr_reg,
  input  logic [DW-1:0]            alu_wr_data,
  output logic                     alu_stall,
  input  logic                     ld_issue,
  input  logic [AW-1:0]            ld_issue_reg,
  input  logic                     ld_rsp_valid,
  input  logic [AW-1:0]            ld_rsp_reg,
  input  logic [DW-1:0]            ld_rsp_data,
  output logic                     ld_rsp_ready,
  input  logic [AW-1:0]            qry_reg1,
  input  logic [AW-1:0]            qry_reg2,
  output logic                     qry_pend1,
  output logic                     qry_pend2,
  output logic [AW-1:0]            rf_dst_reg,
  output logic                     rf_write_reg,
  output logic [DW-1:0]            rf_dst_data,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     sb_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int NREG = 1 << AW;
  localparam logic [PW:0] FullCount = (PW+1)'(DEPTH);

  logic [DW-1:0]   fifoData [DEPTH];
  logic [AW-1:0]   fifoReg  [DEPTH];
  logic [PW-1:0]   wrPtr, rdPtr;
  logic [PW:0]     count;
  logic [NREG-1:0] pending, pendingNext;
  logic            full, empty, push, pop, aluWrite, aluStall, sbErrSet;
  logic [AW-1:0]   headReg;
  logic [DW-1:0]   headData;

  assign full     = (count == FullCount);
  assign empty    = (count == '0);
  assign headReg  = fifoReg[rdPtr];
  assign headData = fifoData[rdPtr];

  // Readiness comes from registered occupancy, so a full FIFO that pops still refuses a push.
  assign ld_rsp_ready = !full;
  assign push         = ld_rsp_valid && !full && (ld_rsp_reg != '0);

  always_comb begin
    aluStall = 1'b0;
    aluWrite = 1'b0;
    pop      = 1'b0;
    if (full) begin
      pop      = 1'b1;
      aluStall = alu_wr_en;
    end else if (alu_wr_en) begin
      // A reg-0 ALU write needs no port, so the FIFO head may use it.
      aluWrite = (alu_wr_reg != '0);
      pop      = !empty && (alu_wr_reg == '0);
    end else begin
      pop = !empty;
    end
  end

  assign alu_stall = aluStall;

  always_comb begin
    pendingNext = pending;
    if (pop)
      pendingNext[headReg] = 1'b0;
    if (ld_issue && (ld_issue_reg != '0))
      pendingNext[ld_issue_reg] = 1'b1;
  end

  // An issue that coincides with the retirement of the same register is a legal reuse.
  assign sbErrSet = ld_issue && (ld_issue_reg != '0) && pending[ld_issue_reg] &&
                    !(pop && (headReg == ld_issue_reg));

  always_ff @(posedge clk) begin
    if (push) begin
      fifoData[wrPtr] <= ld_rsp_data;
      fifoReg[wrPtr]  <= ld_rsp_reg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      count   <= '0;
      pending <= '0;
      sb_err  <= 1'b0;
    end else begin
      if (push)
        wrPtr <= wrPtr + 1'b1;
      if (pop)
        rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      pending <= pendingNext;
      if (sbErrSet)
        sb_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_write_reg <= 1'b0;
      rf_dst_reg   <= '0;
      rf_dst_data  <= '0;
    end else if (pop) begin
      rf_write_reg <= 1'b1;
      rf_dst_reg   <= headReg;
      rf_dst_data  <= headData;
    end else if (aluWrite) begin
      rf_write_reg <= 1'b1;
      rf_dst_reg   <= alu_wr_reg;
      rf_dst_data  <= alu_wr_data;
    end else begin
      rf_write_reg <= 1'b0;
    end
  end

  assign qry_pend1  = pending[qry_reg1];
  assign qry_pend2  = pending[qry_reg2];
  assign fifo_count = count;

endmodule
